// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS main control FSM (fetch/decode/execute/memory/writeback)
// Optional macro MC_CTRL_JAL_EN adds the JAL state (13); otherwise opcode 000011 is illegal.
module mc_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;
  localparam logic [3:0] S_JAL    = 4'd13;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          6'b000000: state_d = (funct == 6'b001000) ? S_JR : S_EXEC;
          6'b100011,
          6'b101011: state_d = S_MEMADR;
          6'b000100,
          6'b000101: state_d = S_BRANCH;
          6'b001000: state_d = S_ADDIEX;
          6'b000010: state_d = S_JUMP;
`ifdef MC_CTRL_JAL_EN
          6'b000011: state_d = S_JAL;
`endif
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        // Any opcode that decodes back to FETCH is unsupported.
        illegal   = (state_d == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        // opcode[0] distinguishes bne from beq.
        pc_en     = zero ^ opcode[0];
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      S_JR: begin
        pc_src = 2'b11;
        pc_en  = 1'b1;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        pc_src    = 2'b10;
        pc_en     = 1'b1;
        reg_write = 1'b1;
        reg_dst   = 2'b10;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_en, reg_write;
  logic [1:0] reg_dst;
  logic       mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic st(input string tag, input logic [3:0] exp);
    tick();
    chk(tag, {4'd0, state}, {4'd0, exp});
  endtask

  // Called in FETCH: loads the next instruction fields and completes the fetch.
  task automatic go(input string tag, input logic [5:0] op, input logic [5:0] fn);
    opcode    = op;
    funct     = fn;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_fetch_state"}, {4'd0, state}, 8'd0);
    chk({tag, "_fetch_irw"}, {7'd0, ir_write}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    tick();
    chk("rst_state", {4'd0, state}, 8'd0);
    chk("rst_mem_req", {7'd0, mem_req}, 8'd1);
    chk("rst_alu_src_b", {6'd0, alu_src_b}, 8'd1);
    chk("rst_pc_en", {7'd0, pc_en}, 8'd0);
    tick();
    rst = 1'b0;

    // lw, reset while stalled in MEMRD
    go("lw0", 6'b100011, 6'd0);
    chk("lw0_pc_en", {7'd0, pc_en}, 8'd1);
    st("lw0_s1", 4'd1);
    mem_ready = 1'b0;
    st("lw0_s2", 4'd2);
    chk("memadr_src_a", {7'd0, alu_src_a}, 8'd1);
    chk("memadr_src_b", {6'd0, alu_src_b}, 8'd2);
    st("lw0_s3", 4'd3);
    chk("memrd_i_or_d", {7'd0, i_or_d}, 8'd1);
    st("lw0_s3_hold", 4'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", {4'd0, state}, 8'd0);
    chk("async_rst_mem_req", {7'd0, mem_req}, 8'd1);
    chk("async_rst_reg_write", {7'd0, reg_write}, 8'd0);
    chk("async_rst_pc_en", {7'd0, pc_en}, 8'd0);
    tick();
    rst = 1'b0;

    // FETCH stalls three cycles, completes on the fourth
    #1;
    chk("stall_c1_state", {4'd0, state}, 8'd0);
    chk("stall_c1_pc_en", {7'd0, pc_en}, 8'd0);
    st("stall_c2_state", 4'd0);
    chk("stall_c2_irw", {7'd0, ir_write}, 8'd0);
    st("stall_c3_state", 4'd0);
    chk("stall_c3_pc_en", {7'd0, pc_en}, 8'd0);
    tick();
    go("lw1", 6'b100011, 6'd0);
    chk("stall_c4_pc_en", {7'd0, pc_en}, 8'd1);
    st("lw1_s1", 4'd1);
    chk("decode_src_b", {6'd0, alu_src_b}, 8'd3);
    st("lw1_s2", 4'd2);
    st("lw1_s3", 4'd3);
    chk("lw1_s3_reg_write", {7'd0, reg_write}, 8'd0);
    st("lw1_s4", 4'd4);
    chk("memwb_reg_write", {7'd0, reg_write}, 8'd1);
    chk("memwb_reg_dst", {6'd0, reg_dst}, 8'd0);
    chk("memwb_mem_to_reg", {7'd0, mem_to_reg}, 8'd1);
    st("lw1_end", 4'd0);

    // sw
    go("sw", 6'b101011, 6'd0);
    st("sw_s1", 4'd1);
    st("sw_s2", 4'd2);
    st("sw_s5", 4'd5);
    chk("memwr_we", {7'd0, mem_we}, 8'd1);
    chk("memwr_req", {7'd0, mem_req}, 8'd1);
    st("sw_end", 4'd0);

    // bne not taken, then taken; beq taken
    zero = 1'b1;
    go("bne_z1", 6'b000101, 6'd0);
    st("bne_z1_s1", 4'd1);
    st("bne_z1_s8", 4'd8);
    chk("bne_z1_pc_en", {7'd0, pc_en}, 8'd0);
    chk("bne_alu_op", {6'd0, alu_op}, 8'd1);
    st("bne_z1_end", 4'd0);
    zero = 1'b0;
    go("bne_z0", 6'b000101, 6'd0);
    st("bne_z0_s1", 4'd1);
    st("bne_z0_s8", 4'd8);
    chk("bne_z0_pc_en", {7'd0, pc_en}, 8'd1);
    chk("bne_z0_pc_src", {6'd0, pc_src}, 8'd1);
    zero = 1'b1;
    st("bne_z0_end", 4'd0);
    go("beq_z1", 6'b000100, 6'd0);
    st("beq_s1", 4'd1);
    st("beq_s8", 4'd8);
    chk("beq_z1_pc_en", {7'd0, pc_en}, 8'd1);
    zero = 1'b0;
    st("beq_end", 4'd0);

    // R-type add; mem_ready low outside memory states must not matter
    go("add", 6'b000000, 6'b100000);
    st("add_s1", 4'd1);
    mem_ready = 1'b0;
    st("add_s6", 4'd6);
    chk("exec_alu_op", {6'd0, alu_op}, 8'd2);
    st("add_s7", 4'd7);
    chk("aluwb_reg_dst", {6'd0, reg_dst}, 8'd1);
    chk("aluwb_reg_write", {7'd0, reg_write}, 8'd1);
    mem_ready = 1'b1;
    st("add_end", 4'd0);

    // jr
    go("jr", 6'b000000, 6'b001000);
    st("jr_s1", 4'd1);
    st("jr_s12", 4'd12);
    chk("jr_pc_src", {6'd0, pc_src}, 8'd3);
    chk("jr_pc_en", {7'd0, pc_en}, 8'd1);
    st("jr_end", 4'd0);

    // addi
    go("addi", 6'b001000, 6'd0);
    st("addi_s1", 4'd1);
    st("addi_s9", 4'd9);
    chk("addiex_src_b", {6'd0, alu_src_b}, 8'd2);
    st("addi_s10", 4'd10);
    chk("addiwb_reg_write", {7'd0, reg_write}, 8'd1);
    chk("addiwb_reg_dst", {6'd0, reg_dst}, 8'd0);
    st("addi_end", 4'd0);

    // j
    go("j", 6'b000010, 6'd0);
    st("j_s1", 4'd1);
    chk("j_decode_illegal", {7'd0, illegal}, 8'd0);
    st("j_s11", 4'd11);
    chk("j_pc_src", {6'd0, pc_src}, 8'd2);
    chk("j_pc_en", {7'd0, pc_en}, 8'd1);
    st("j_end", 4'd0);

    // unsupported opcode
    go("ill", 6'b111111, 6'd0);
    st("ill_s1", 4'd1);
    chk("ill_pulse", {7'd0, illegal}, 8'd1);
    st("ill_end", 4'd0);
    chk("ill_pulse_end", {7'd0, illegal}, 8'd0);

    // opcode 000011
    go("jal", 6'b000011, 6'd0);
    st("jal_s1", 4'd1);
`ifdef MC_CTRL_JAL_EN
    chk("jal_illegal", {7'd0, illegal}, 8'd0);
    st("jal_s13", 4'd13);
    chk("jal_reg_dst", {6'd0, reg_dst}, 8'd2);
    chk("jal_reg_write", {7'd0, reg_write}, 8'd1);
    chk("jal_pc_src", {6'd0, pc_src}, 8'd2);
    chk("jal_pc_en", {7'd0, pc_en}, 8'd1);
    st("jal_end", 4'd0);
`else
    chk("jal_illegal", {7'd0, illegal}, 8'd1);
    st("jal_end", 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
